// File: rtl/pbkdf2_f_block.sv
// PBKDF2-HMAC-SHA256 block function F(P,S,c,i): drives an external HMAC core
// iteratively, XOR-accumulating each PRF output into one 256-bit derived block.
module pbkdf2_f_block #(
  parameter int ITER_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              v_i,
  output logic              r_o,
  input  logic [511:0]      pwd_i,
  input  logic [511:0]      salt_i,
  input  logic [5:0]        salt_len_i,
  input  logic [31:0]       blk_idx_i,
  input  logic [ITER_W-1:0] iter_i,
  output logic [255:0]      dk_o,
  output logic              err_o,
  output logic              v_o,
  input  logic              r_i,
  output logic [511:0]      hmac_key_o,
  output logic [511:0]      hmac_msg_o,
  output logic [5:0]        hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [255:0]      hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [511:0]        key_q, key_d;
  logic [511:0]        msg_q, msg_d;
  logic [5:0]          len_q, len_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [255:0]        acc_q, acc_d;
  logic                err_q, err_d;

  logic [8:0]          salt_bits;
  logic [511:0]        salt_mask;
  logic [511:0]        idx_shifted;

  // First message is salt bytes followed immediately by INT(i) big-endian.
  assign salt_bits   = {salt_len_i, 3'b000};
  assign salt_mask   = ~({512{1'b1}} >> salt_bits);
  assign idx_shifted = {blk_idx_i, 480'b0} >> salt_bits;

  // Every handshake (v_i/r_o, v_o/r_i, hmac_v_o/hmac_r_i, hmac_v_i/hmac_r_o)
  // transfers on a rising edge where valid and ready are both high; valid
  // never depends combinationally on ready and payloads hold while valid waits.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    msg_d   = msg_q;
    len_d   = len_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (v_i) begin
          key_d  = pwd_i;
          iter_d = (iter_i == '0) ? ITER_ONE : iter_i;
          acc_d  = '0;
          cnt_d  = ITER_ONE;
          if (salt_len_i > 6'd51) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            msg_d   = (salt_i & salt_mask) | idx_shifted;
            len_d   = salt_len_i + 6'd4;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (hmac_r_i) state_d = WAIT;
      end
      WAIT: begin
        if (hmac_v_i) begin
          acc_d = acc_q ^ hmac_prf_i;
          msg_d = {hmac_prf_i, 256'b0};
          len_d = 6'd32;
          // Compare before increment so an all-ones count ends without wrapping.
          if (cnt_q == iter_q) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + ITER_ONE;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (r_i) begin
          err_d   = 1'b0;
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      key_q   <= '0;
      msg_q   <= '0;
      len_q   <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // HMAC muxes its pads on v_i, so hmac_v_o is a pure decode of ISSUE.
  assign r_o        = (state_q == IDLE);
  assign hmac_v_o   = (state_q == ISSUE);
  assign hmac_r_o   = (state_q == WAIT);
  assign v_o        = (state_q == DONE);
  assign dk_o       = (state_q == DONE) ? acc_q : '0;
  assign err_o      = err_q;
  assign hmac_key_o = key_q;
  assign hmac_msg_o = msg_q;
  assign hmac_len_o = len_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pbkdf2_f_block.sv
// Bench for pbkdf2_f_block: a real HMAC-SHA256 responder model behind the DUT,
// vector table plus random requests checked against a direct PBKDF2 F model.
module tb_pbkdf2_f_block;

  logic         clk_i;
  logic         rst_ni;
  logic         v_i;
  logic         r_o;
  logic [511:0] pwd_i;
  logic [511:0] salt_i;
  logic [5:0]   salt_len_i;
  logic [31:0]  blk_idx_i;
  logic [31:0]  iter_i;
  logic [255:0] dk_o;
  logic         err_o;
  logic         v_o;
  logic         r_i;
  logic [511:0] hmac_key_o;
  logic [511:0] hmac_msg_o;
  logic [5:0]   hmac_len_o;
  logic         hmac_v_o;
  logic         hmac_r_i;
  logic [255:0] hmac_prf_i;
  logic         hmac_v_i;
  logic         hmac_r_o;
  logic [1:0]   state_o;

  int n_checks = 0;
  int n_errs   = 0;

  pbkdf2_f_block #(.ITER_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .v_i(v_i), .r_o(r_o),
    .pwd_i(pwd_i), .salt_i(salt_i), .salt_len_i(salt_len_i),
    .blk_idx_i(blk_idx_i), .iter_i(iter_i), .dk_o(dk_o), .err_o(err_o),
    .v_o(v_o), .r_i(r_i), .hmac_key_o(hmac_key_o), .hmac_msg_o(hmac_msg_o),
    .hmac_len_o(hmac_len_o), .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i),
    .hmac_prf_i(hmac_prf_i), .hmac_v_i(hmac_v_i), .hmac_r_o(hmac_r_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SHA-256 / HMAC reference ----------------
  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] SHA_H0 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K256[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // SHA-256 of the first nbytes (<=119) of d, which always fits two blocks.
  function automatic logic [255:0] sha_2blk(input logic [1023:0] d, input int nbytes);
    logic [1023:0] p;
    logic [255:0]  h;
    logic [63:0]   bits;
    p = '0;
    for (int k = 0; k < nbytes; k++) p[1023-8*k -: 8] = d[1023-8*k -: 8];
    p[1023-8*nbytes -: 8] = 8'h80;
    bits = 64'(nbytes) << 3;
    p[63:0] = bits;
    h = sha_comp(SHA_H0, p[1023:512]);
    h = sha_comp(h, p[511:0]);
    return h;
  endfunction

  function automatic logic [255:0] hmac_ref(input logic [511:0] key, input logic [511:0] msg,
                                            input int len);
    logic [511:0] ipad, opad;
    logic [255:0] inner;
    ipad  = {64{8'h36}};
    opad  = {64{8'h5c}};
    inner = sha_2blk({key ^ ipad, msg}, 64 + len);
    return sha_2blk({key ^ opad, inner, 256'b0}, 96);
  endfunction

  // F(P,S,c,i) straight from its definition: U1 = PRF(P, S||INT(i)), Uj = PRF(P, Uj-1).
  function automatic logic [255:0] f_model(input logic [511:0] pwd, input logic [511:0] salt,
                                           input int l, input logic [31:0] idx, input int c);
    logic [511:0] m;
    logic [255:0] u, t;
    if (l > 51) return '0;
    m = '0;
    for (int k = 0; k < l; k++) m[511-8*k -: 8] = salt[511-8*k -: 8];
    for (int k = 0; k < 4; k++) m[511-8*(l+k) -: 8] = idx[31-8*k -: 8];
    if (c == 0) c = 1;
    u = hmac_ref(pwd, m, l + 4);
    t = u;
    for (int j = 1; j < c; j++) begin
      u = hmac_ref(pwd, {u, 256'b0}, 32);
      t = t ^ u;
    end
    return t;
  endfunction

  // ---------------- HMAC responder (downstream core stand-in) ----------------
  logic         rs_busy;
  logic         rs_rdy;
  logic [255:0] rs_prf;
  int           rs_wait;
  int           hs_cnt = 0;
  int           vcyc   = 0;

  assign hmac_r_i = !rs_busy && rs_rdy;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs_busy    <= 1'b0;
      rs_rdy     <= 1'b1;
      rs_prf     <= '0;
      rs_wait    <= 0;
      hmac_v_i   <= 1'b0;
      hmac_prf_i <= '0;
    end else begin
      rs_rdy <= ($urandom_range(0, 3) != 0);
      if (!rs_busy) begin
        if (hmac_v_o && hmac_r_i) begin
          rs_busy <= 1'b1;
          rs_prf  <= hmac_ref(hmac_key_o, hmac_msg_o, int'(hmac_len_o));
          rs_wait <= $urandom_range(0, 2);
        end
      end else if (hmac_v_i) begin
        if (hmac_r_o) begin
          hmac_v_i <= 1'b0;
          rs_busy  <= 1'b0;
        end
      end else if (rs_wait == 0) begin
        hmac_v_i   <= 1'b1;
        hmac_prf_i <= rs_prf;
      end else begin
        rs_wait <= rs_wait - 1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && hmac_v_o && hmac_r_i) hs_cnt <= hs_cnt + 1;
    if (rst_ni && hmac_v_o) vcyc <= vcyc + 1;
  end

  // ---------------- scoreboard helpers / drivers ----------------
  typedef struct {
    logic [511:0] pwd;
    logic [511:0] salt;
    logic [5:0]   len;
    logic [31:0]  idx;
    logic [31:0]  iter;
    logic [255:0] dk;
    logic         err;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_req(input vec_t v, input int hold, output logic [255:0] dk,
                         output logic err, output int nhs, output int nvc);
    int base_hs, base_vc, n, budget;
    budget  = ((v.iter == 0) ? 1 : int'(v.iter)) * 12 + 50;
    base_hs = hs_cnt;
    base_vc = vcyc;
    pwd_i = v.pwd; salt_i = v.salt; salt_len_i = v.len;
    blk_idx_i = v.idx; iter_i = v.iter; v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    n = 0;
    while (!v_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk("v_o within budget", {255'b0, v_o}, 256'd1);
    dk  = dk_o;
    err = err_o;
    for (int h = 0; h < hold; h++) begin
      v_i = 1'b1;
      pwd_i = rand512();
      salt_len_i = 6'd3;
      @(negedge clk_i);
      chk("hold dk_o stable", dk_o, dk);
      chk("hold r_o low", {255'b0, r_o}, 256'd0);
      chk("hold v_o high", {255'b0, v_o}, 256'd1);
    end
    v_i = 1'b0;
    nhs = hs_cnt - base_hs;
    nvc = vcyc - base_vc;
    r_i = 1'b1;
    @(negedge clk_i);
    r_i = 1'b0;
    chk("post accept r_o", {255'b0, r_o}, 256'd1);
    chk("post accept v_o", {255'b0, v_o}, 256'd0);
    chk("post accept err_o", {255'b0, err_o}, 256'd0);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [511:0] PWD  = {64'h70617373776f7264, 448'b0};
  localparam logic [511:0] SALT = {32'h73616c74, 480'b0};
  localparam logic [255:0] DK1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] DK2 = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [255:0] DK4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

  vec_t         vt [10];
  vec_t         v;
  logic [255:0] dk;
  logic         err;
  int           nhs, nvc, base, n, exp_hs;

  initial begin
    rst_ni = 1'b0; v_i = 1'b0; r_i = 1'b0;
    pwd_i = '0; salt_i = '0; salt_len_i = '0; blk_idx_i = '0; iter_i = '0;

    vt[0] = '{PWD, SALT, 6'd4, 32'd1, 32'd1, DK1, 1'b0};
    vt[1] = '{PWD, SALT, 6'd4, 32'd1, 32'd2, DK2, 1'b0};
    vt[2] = '{PWD, SALT, 6'd4, 32'd1, 32'd0, DK1, 1'b0};
    vt[3] = '{PWD, SALT, 6'd52, 32'd1, 32'd3, 256'd0, 1'b1};
    vt[4] = '{rand512(), rand512(), 6'd63, 32'd7, 32'd1, 256'd0, 1'b1};
    for (int i = 5; i < 10; i++) begin
      vt[i].pwd  = rand512();
      vt[i].salt = rand512();
      vt[i].len  = (i == 5) ? 6'd51 : (i == 6) ? 6'd0 : 6'($urandom_range(0, 51));
      vt[i].idx  = $urandom;
      vt[i].iter = $urandom_range(1, 4);
      vt[i].dk   = f_model(vt[i].pwd, vt[i].salt, int'(vt[i].len), vt[i].idx, int'(vt[i].iter));
      vt[i].err  = 1'b0;
    end

    repeat (3) @(negedge clk_i);
    chk("reset r_o", {255'b0, r_o}, 256'd1);
    chk("reset v_o", {255'b0, v_o}, 256'd0);
    chk("reset err_o", {255'b0, err_o}, 256'd0);
    chk("reset dk_o", dk_o, 256'd0);
    chk("reset hmac_v_o", {255'b0, hmac_v_o}, 256'd0);
    chk("reset hmac_r_o", {255'b0, hmac_r_o}, 256'd0);
    chk("reset hmac_key_o", hmac_key_o[255:0] | hmac_key_o[511:256], 256'd0);
    chk("reset hmac_msg_o", hmac_msg_o[255:0] | hmac_msg_o[511:256], 256'd0);
    chk("reset hmac_len_o", {250'b0, hmac_len_o}, 256'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 10; i++) begin
      run_req(vt[i], 0, dk, err, nhs, nvc);
      exp_hs = vt[i].err ? 0 : ((vt[i].iter == 0) ? 1 : int'(vt[i].iter));
      chk($sformatf("vec%0d dk_o", i), dk, vt[i].dk);
      chk($sformatf("vec%0d err_o", i), {255'b0, err}, {255'b0, vt[i].err});
      chk($sformatf("vec%0d hmac handshakes", i), 256'(nhs), 256'(exp_hs));
      if (vt[i].err) chk($sformatf("vec%0d hmac_v_o cycles", i), 256'(nvc), 256'd0);
    end

    v = '{PWD, SALT, 6'd4, 32'd1, 32'd4096, DK4096, 1'b0};
    run_req(v, 0, dk, err, nhs, nvc);
    chk("c4096 dk_o", dk, DK4096);
    chk("c4096 hmac handshakes", 256'(nhs), 256'd4096);

    v = '{PWD, SALT, 6'd4, 32'd1, 32'd1, DK1, 1'b0};
    run_req(v, 20, dk, err, nhs, nvc);
    chk("backpressure dk_o", dk, DK1);
    chk("backpressure handshakes", 256'(nhs), 256'd1);
    v = '{PWD, SALT, 6'd4, 32'd1, 32'd2, DK2, 1'b0};
    run_req(v, 0, dk, err, nhs, nvc);
    chk("after backpressure dk_o", dk, DK2);

    base = hs_cnt;
    pwd_i = PWD; salt_i = SALT; salt_len_i = 6'd4; blk_idx_i = 32'd1; iter_i = 32'd4096;
    v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    n = 0;
    while ((hs_cnt - base) < 3 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach iteration 3", {255'b0, (hs_cnt - base) >= 3}, 256'd1);
    chk("mid-run key present", {255'b0, hmac_key_o == PWD}, 256'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort r_o", {255'b0, r_o}, 256'd1);
    chk("abort v_o", {255'b0, v_o}, 256'd0);
    chk("abort err_o", {255'b0, err_o}, 256'd0);
    chk("abort dk_o", dk_o, 256'd0);
    chk("abort hmac_v_o", {255'b0, hmac_v_o}, 256'd0);
    chk("abort hmac_r_o", {255'b0, hmac_r_o}, 256'd0);
    chk("abort hmac_key_o", hmac_key_o[255:0] | hmac_key_o[511:256], 256'd0);
    chk("abort hmac_msg_o", hmac_msg_o[255:0] | hmac_msg_o[511:256], 256'd0);
    chk("abort hmac_len_o", {250'b0, hmac_len_o}, 256'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    v = '{PWD, SALT, 6'd4, 32'd1, 32'd1, DK1, 1'b0};
    run_req(v, 0, dk, err, nhs, nvc);
    chk("after abort dk_o", dk, DK1);
    chk("after abort handshakes", 256'(nhs), 256'd1);

    for (int i = 0; i < 6; i++) begin
      v.pwd  = rand512();
      v.salt = rand512();
      v.len  = 6'($urandom_range(0, 55));
      v.idx  = $urandom;
      v.iter = $urandom_range(0, 5);
      v.err  = (v.len > 6'd51);
      v.dk   = f_model(v.pwd, v.salt, int'(v.len), v.idx, int'(v.iter));
      run_req(v, $urandom_range(0, 3), dk, err, nhs, nvc);
      chk($sformatf("rand%0d dk_o", i), dk, v.dk);
      chk($sformatf("rand%0d err_o", i), {255'b0, err}, {255'b0, v.err});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
